// File: rtl/vote_tally_bcd.sv
// Per-candidate BCD vote tallies with saturation, followed by a sequential scan for the leader.
// Vote ack/err are registered one cycle after the request; the scan takes NUM_CAND cycles after close.
module vote_tally_bcd #(
    parameter int NUM_CAND   = 5,
    parameter int NUM_DIGITS = 6,
    parameter int ID_W       = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    vote_valid,
    input  logic [ID_W-1:0]         vote_id,
    input  logic                    close,
    input  logic [ID_W-1:0]         rd_sel,
    output logic [4*NUM_DIGITS-1:0] rd_count,
    output logic                    vote_ack,
    output logic                    vote_err,
    output logic [NUM_CAND-1:0]     sat,
    output logic                    closed,
    output logic                    result_valid,
    output logic [ID_W-1:0]         leader_id,
    output logic [4*NUM_DIGITS-1:0] leader_count,
    output logic                    tie
);

    localparam int CW = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {S_OPEN, S_SCAN, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   tally_q [NUM_CAND];
    logic [NUM_CAND-1:0] sat_q;
    logic [ID_W-1:0] scan_idx_q;
    logic [ID_W-1:0] best_id_q;
    logic [CW-1:0]   best_cnt_q;
    logic            tie_q;
    logic            ack_q;
    logic            err_q;

    logic            vote_hit;
    logic            vote_sat;
    logic            accept;
    logic [CW-1:0]   vote_cur;
    logic [CW-1:0]   tally_d;
    logic [CW-1:0]   scan_cur;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [CW-1:0] v);
        logic r;
        r = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (v[4*d +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    // Out-of-range selects never match, so they fall through to zero / no-hit.
    always_comb begin
        vote_hit = 1'b0;
        vote_sat = 1'b0;
        vote_cur = '0;
        scan_cur = '0;
        rd_count = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            if (vote_id == ID_W'(c)) begin
                vote_hit = 1'b1;
                vote_sat = sat_q[c];
                vote_cur = tally_q[c];
            end
            if (scan_idx_q == ID_W'(c)) scan_cur = tally_q[c];
            if (rd_sel == ID_W'(c))     rd_count = tally_q[c];
        end
    end

    assign tally_d = bcd_inc(vote_cur);
    assign accept  = vote_valid && (state_q == S_OPEN) && vote_hit && !vote_sat;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_OPEN;
            sat_q      <= '0;
            scan_idx_q <= '0;
            best_id_q  <= '0;
            best_cnt_q <= '0;
            tie_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            for (int c = 0; c < NUM_CAND; c++) tally_q[c] <= '0;
        end else begin
            ack_q <= accept;
            err_q <= vote_valid && !accept;
            for (int c = 0; c < NUM_CAND; c++) begin
                if (accept && vote_id == ID_W'(c)) begin
                    tally_q[c] <= tally_d;
                    if (all_nines(tally_d)) sat_q[c] <= 1'b1;
                end
            end

            case (state_q)
                S_OPEN: begin
                    if (close) begin
                        state_q    <= S_SCAN;
                        scan_idx_q <= '0;
                    end
                end
                S_SCAN: begin
                    // Only a strictly larger tally moves the leader, so ties keep the lowest index.
                    if (scan_idx_q == '0 || scan_cur > best_cnt_q) begin
                        best_cnt_q <= scan_cur;
                        best_id_q  <= scan_idx_q;
                        tie_q      <= 1'b0;
                    end else if (scan_cur == best_cnt_q) begin
                        tie_q      <= 1'b1;
                    end
                    if (scan_idx_q == ID_W'(NUM_CAND - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_DONE;
                default: state_q <= S_OPEN;
            endcase
        end
    end

    assign vote_ack     = ack_q;
    assign vote_err     = err_q;
    assign sat          = sat_q;
    assign closed       = (state_q != S_OPEN);
    assign result_valid = (state_q == S_DONE);
    assign leader_id    = result_valid ? best_id_q  : '0;
    assign leader_count = result_valid ? best_cnt_q : '0;
    assign tie          = result_valid ? tie_q      : 1'b0;

endmodule

// File: tb/tb_vote_tally_bcd.sv
// Bench for vote_tally_bcd: vector table, directed corner sequences and randomized
// elections checked against a decimal-count reference model.
module tb_vote_tally_bcd;

    localparam int NC   = 5;
    localparam int MAXC = 999999;

    logic        clock;
    logic        reset;
    logic        vote_valid, close;
    logic [2:0]  vote_id, rd_sel;
    logic [23:0] rd_count, leader_count;
    logic        vote_ack, vote_err, closed, result_valid, tie;
    logic [4:0]  sat;
    logic [2:0]  leader_id;

    logic        vv2, close2;
    logic [2:0]  vid2, rsel2, lid2;
    logic [7:0]  rd2, lc2;
    logic        ack2, err2, closed2, rv2, tie2;
    logic [4:0]  sat2;

    vote_tally_bcd u_dut (
        .clock(clock), .reset(reset), .vote_valid(vote_valid), .vote_id(vote_id),
        .close(close), .rd_sel(rd_sel), .rd_count(rd_count), .vote_ack(vote_ack),
        .vote_err(vote_err), .sat(sat), .closed(closed), .result_valid(result_valid),
        .leader_id(leader_id), .leader_count(leader_count), .tie(tie)
    );

    vote_tally_bcd #(.NUM_CAND(5), .NUM_DIGITS(2), .ID_W(3)) u_dut2 (
        .clock(clock), .reset(reset), .vote_valid(vv2), .vote_id(vid2),
        .close(close2), .rd_sel(rsel2), .rd_count(rd2), .vote_ack(ack2),
        .vote_err(err2), .sat(sat2), .closed(closed2), .result_valid(rv2),
        .leader_id(lid2), .leader_count(lc2), .tie(tie2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    int mcnt [NC];
    bit m_open;

    typedef struct {
        int          vid;
        bit          ack;
        bit          err;
        int          rsel;
        logic [23:0] cnt;
    } row_t;

    row_t rows [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          x;
        x = v;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] exp_rd(input int rs);
        return (rs < NC) ? to_bcd(mcnt[rs]) : 24'h0;
    endfunction

    task automatic model_reset;
        for (int c = 0; c < NC; c++) mcnt[c] = 0;
        m_open = 1'b1;
    endtask

    task automatic do_reset;
        reset = 1'b1; vote_valid = 1'b0; close = 1'b0; vv2 = 1'b0;
        tick;
        reset = 1'b0;
        model_reset;
    endtask

    task automatic cycle_chk(input bit vv, input int id, input int rs, input string tag);
        bit exp_ack, exp_err;
        exp_ack = vv && m_open && (id < NC) && (mcnt[id] < MAXC);
        exp_err = vv && !exp_ack;
        vote_valid = vv; vote_id = 3'(id); rd_sel = 3'(rs);
        tick;
        vote_valid = 1'b0;
        if (exp_ack) mcnt[id]++;
        chk({tag, " ack"}, 32'(vote_ack), 32'(exp_ack));
        chk({tag, " err"}, 32'(vote_err), 32'(exp_err));
        chk({tag, " rd_count"}, 32'(rd_count), 32'(exp_rd(rs)));
    endtask

    task automatic wait_result(input string tag);
        int k, mx, lid, nmx;
        k = 0;
        while (!result_valid && k < 40) begin
            tick;
            k++;
        end
        chk({tag, " scan cycles"}, 32'(k), 32'(NC));
        mx = 0; lid = 0; nmx = 0;
        for (int c = 0; c < NC; c++) if (mcnt[c] > mx) mx = mcnt[c];
        for (int c = NC - 1; c >= 0; c--) if (mcnt[c] == mx) begin lid = c; nmx++; end
        chk({tag, " leader_id"}, 32'(leader_id), 32'(lid));
        chk({tag, " leader_count"}, 32'(leader_count), 32'(to_bcd(mx)));
        chk({tag, " tie"}, 32'(tie), 32'(nmx > 1));
    endtask

    task automatic close_and_check(input string tag);
        close = 1'b1;
        tick;
        close = 1'b0;
        m_open = 1'b0;
        chk({tag, " closed"}, 32'(closed), 32'd1);
        chk({tag, " rv early"}, 32'(result_valid), 32'd0);
        chk({tag, " leader masked"}, 32'({leader_id, leader_count, tie}), 32'd0);
        wait_result(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; vote_valid = 1'b0; vote_id = '0; close = 1'b0; rd_sel = '0;
        vv2 = 1'b0; vid2 = '0; close2 = 1'b0; rsel2 = '0;
        model_reset;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        for (int c = 0; c < 8; c++) begin
            rd_sel = 3'(c);
            #1;
            chk("reset rd_count", 32'(rd_count), 32'd0);
        end
        chk("reset sat", 32'(sat), 32'd0);
        chk("reset ack/err", 32'({vote_ack, vote_err}), 32'd0);
        chk("reset closed/rv", 32'({closed, result_valid}), 32'd0);
        chk("reset leader", 32'({leader_id, leader_count, tie}), 32'd0);
        chk("reset dut2", 32'({sat2, closed2, rv2, lid2, lc2, tie2, ack2, err2}), 32'd0);

        // Vector table: counting, out-of-range id, readout of unused select
        rows[0] = '{0, 1'b1, 1'b0, 0, 24'h000001};
        rows[1] = '{0, 1'b1, 1'b0, 0, 24'h000002};
        rows[2] = '{0, 1'b1, 1'b0, 0, 24'h000003};
        rows[3] = '{2, 1'b1, 1'b0, 2, 24'h000001};
        rows[4] = '{5, 1'b0, 1'b1, 5, 24'h000000};
        rows[5] = '{7, 1'b0, 1'b1, 0, 24'h000003};
        for (int i = 0; i < 6; i++) begin
            vote_valid = 1'b1; vote_id = 3'(rows[i].vid); rd_sel = 3'(rows[i].rsel);
            tick;
            vote_valid = 1'b0;
            chk($sformatf("row%0d ack", i), 32'(vote_ack), 32'(rows[i].ack));
            chk($sformatf("row%0d err", i), 32'(vote_err), 32'(rows[i].err));
            chk($sformatf("row%0d rd_count", i), 32'(rd_count), 32'(rows[i].cnt));
        end
        rd_sel = 3'd2;
        tick;
        chk("pulse ends", 32'({vote_ack, vote_err}), 32'd0);
        chk("tally 2 unchanged", 32'(rd_count), 32'h000001);

        // BCD carry
        do_reset;
        for (int i = 0; i < 10; i++) cycle_chk(1'b1, 1, 1, "carry");
        chk("carry to tens", 32'(rd_count), 32'h000010);
        for (int i = 0; i < 90; i++) cycle_chk(1'b1, 1, 1, "carry");
        chk("carry to hundreds", 32'(rd_count), 32'h000100);

        // Saturation on the two-digit instance
        do_reset;
        rsel2 = 3'd3;
        for (int i = 0; i < 98; i++) begin
            vv2 = 1'b1; vid2 = 3'd3;
            tick;
            vv2 = 1'b0;
        end
        chk("sat2 at 98", 32'({sat2, rd2}), 32'({5'b00000, 8'h98}));
        vv2 = 1'b1; tick; vv2 = 1'b0;
        chk("sat2 ack at 99", 32'({ack2, err2}), 32'b10);
        chk("sat2 at 99", 32'({sat2, rd2}), 32'({5'b01000, 8'h99}));
        vv2 = 1'b1; tick; vv2 = 1'b0;
        chk("sat2 reject", 32'({ack2, err2}), 32'b01);
        chk("sat2 holds", 32'(rd2), 32'h99);

        // Election with tie between 1 and 2
        do_reset;
        for (int i = 0; i < 2; i++) cycle_chk(1'b1, 0, 0, "elect");
        for (int i = 0; i < 5; i++) cycle_chk(1'b1, 1, 1, "elect");
        for (int i = 0; i < 5; i++) cycle_chk(1'b1, 2, 2, "elect");
        cycle_chk(1'b1, 4, 4, "elect");
        close_and_check("elect");
        chk("elect leader const", 32'({leader_id, leader_count, tie}), 32'({3'd1, 24'h000005, 1'b1}));
        cycle_chk(1'b1, 0, 2, "vote after done");
        close = 1'b1; tick; close = 1'b0;
        chk("done stable", 32'({result_valid, leader_id, leader_count, tie}),
            32'({1'b1, 3'd1, 24'h000005, 1'b1}));

        // Vote and close in the same cycle
        do_reset;
        vote_valid = 1'b1; vote_id = 3'd4; close = 1'b1; rd_sel = 3'd4;
        tick;
        vote_valid = 1'b0; close = 1'b0;
        mcnt[4]++; m_open = 1'b0;
        chk("vote+close ack", 32'({vote_ack, vote_err, closed}), 32'b101);
        chk("vote+close tally", 32'(rd_count), 32'h000001);
        wait_result("vote+close");

        // Reset in the middle of a scan, with a coincident vote and close
        do_reset;
        for (int i = 0; i < 3; i++) cycle_chk(1'b1, 2, 2, "midscan");
        close = 1'b1; tick; close = 1'b0;
        tick;
        reset = 1'b1; vote_valid = 1'b1; vote_id = 3'd0; close = 1'b1;
        tick;
        reset = 1'b0; vote_valid = 1'b0; close = 1'b0;
        model_reset;
        chk("midscan closed/rv", 32'({closed, result_valid}), 32'd0);
        chk("midscan ack/err", 32'({vote_ack, vote_err}), 32'd0);
        for (int c = 0; c < NC; c++) begin
            rd_sel = 3'(c);
            #1;
            chk("midscan rd_count", 32'(rd_count), 32'd0);
        end
        cycle_chk(1'b1, 0, 0, "midscan reopen");

        // Randomized elections
        for (int r = 0; r < 6; r++) begin
            do_reset;
            for (int i = 0; i < 25; i++)
                cycle_chk(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 7)), "rand");
            close_and_check("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
